// File: rtl/kws_pkg.sv
// Shared types and constants for the keyword-spotting decision block.
// Latency: none (declarations only).
// Backpressure: none; the datapath is a free-running per-frame pipeline.
package kws_pkg;

  localparam int NUM_CLASSES = 8;
  localparam int CLS_W       = 3;
  localparam int DATA_W      = 16;

  typedef logic signed [DATA_W-1:0] prob_t;
  typedef logic [CLS_W-1:0]         cls_t;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    REFRACT
  } state_e;

  // Q0.15 reference points: 1.0 (saturated) and the default 0.6 threshold
  localparam prob_t Q15_ONE    = 16'sd32767;
  localparam prob_t THRESH_0P6 = 16'sd19661;

  // Signed maximum of two probabilities
  function automatic prob_t prob_max(input prob_t a, input prob_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kws_decision_if.sv
// Frame input / detection output bundle between softmax stage and controller.
// Latency: n/a (wiring only).
// Backpressure: none; producer presents a frame on in_valid, consumer must accept.
interface kws_decision_if;
  import kws_pkg::*;

  logic  in_valid;
  prob_t prob_0, prob_1, prob_2, prob_3, prob_4, prob_5, prob_6, prob_7;
  logic  flush;

  logic  frame_valid;
  cls_t  frame_class;
  prob_t frame_conf;
  logic  detect_valid;
  cls_t  detect_class;
  prob_t detect_conf;
  logic  busy;

  // Upstream/controller side
  modport master (
    output in_valid, prob_0, prob_1, prob_2, prob_3, prob_4, prob_5, prob_6, prob_7, flush,
    input  frame_valid, frame_class, frame_conf, detect_valid, detect_class, detect_conf, busy
  );

  // Decision block side
  modport slave (
    input  in_valid, prob_0, prob_1, prob_2, prob_3, prob_4, prob_5, prob_6, prob_7, flush,
    output frame_valid, frame_class, frame_conf, detect_valid, detect_class, detect_conf, busy
  );

endinterface

// File: rtl/kws_argmax8.sv
// Registered 8-way signed argmax, ties resolved to the lowest class index.
// Latency: 1 cycle from in_valid_i to frame_valid_o.
// Backpressure: none; flush_i kills the in-flight result, class/conf hold their last value.
module kws_argmax8
  import kws_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid_i,
  input  logic  flush_i,
  input  prob_t prob_i [NUM_CLASSES],
  output logic  frame_valid_o,
  output cls_t  frame_class_o,
  output prob_t frame_conf_o
);

  cls_t  best_cls;
  prob_t best_conf;
  logic  frame_valid_q;
  cls_t  frame_class_q;
  prob_t frame_conf_q;

  // Strict greater-than scan keeps the earliest index on ties
  always_comb begin
    best_cls  = '0;
    best_conf = prob_i[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (prob_i[i] > best_conf) begin
        best_conf = prob_i[i];
        best_cls  = cls_t'(i);
      end
    end
  end

  // Result register; a frame arriving with flush is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q <= 1'b0;
      frame_class_q <= '0;
      frame_conf_q  <= '0;
    end else if (flush_i) begin
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= in_valid_i;
      if (in_valid_i) begin
        frame_class_q <= best_cls;
        frame_conf_q  <= best_conf;
      end
    end
  end

  assign frame_valid_o = frame_valid_q;
  assign frame_class_o = frame_class_q;
  assign frame_conf_o  = frame_conf_q;

endmodule

// File: rtl/kws_decision.sv
// Keyword decision: per-frame argmax, then a run/refractory FSM emitting one detect pulse.
// Latency: 2 cycles from the deciding frame's in_valid to detect_valid.
// Backpressure: none; flush aborts tracking and drops the in-flight frame.
module kws_decision
  import kws_pkg::*;
#(
  parameter prob_t THRESH         = THRESH_0P6,
  parameter int    HOLD_FRAMES    = 3,
  parameter int    REFRACT_FRAMES = 8,
  parameter int    SILENCE_CLASS  = 0
) (
  input  logic clk,
  input  logic rst,
  kws_decision_if.slave bus
);

  localparam logic [3:0] HOLD_CNT    = 4'(HOLD_FRAMES);
  localparam logic [7:0] REFRACT_CNT = 8'(REFRACT_FRAMES);
  localparam cls_t       SIL_CLS     = cls_t'(SILENCE_CLASS);

  prob_t prob_vec [NUM_CLASSES];
  logic  frame_valid;
  cls_t  frame_class;
  prob_t frame_conf;
  logic  qualify;
  logic  trig;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcnt_q, rcnt_d;
  cls_t       cand_q, cand_d;
  prob_t      peak_q, peak_d;
  logic       det_vld_q, det_vld_d;
  cls_t       det_cls_q, det_cls_d;
  prob_t      det_conf_q, det_conf_d;

  assign prob_vec[0] = bus.prob_0;
  assign prob_vec[1] = bus.prob_1;
  assign prob_vec[2] = bus.prob_2;
  assign prob_vec[3] = bus.prob_3;
  assign prob_vec[4] = bus.prob_4;
  assign prob_vec[5] = bus.prob_5;
  assign prob_vec[6] = bus.prob_6;
  assign prob_vec[7] = bus.prob_7;

  kws_argmax8 u_argmax (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (bus.in_valid),
    .flush_i       (bus.flush),
    .prob_i        (prob_vec),
    .frame_valid_o (frame_valid),
    .frame_class_o (frame_class),
    .frame_conf_o  (frame_conf)
  );

  assign qualify = frame_valid && (frame_conf >= THRESH) && (frame_class != SIL_CLS);

  // Next-state: run tracking, trigger decision and refractory countdown
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    cand_d     = cand_q;
    peak_d     = peak_q;
    det_vld_d  = 1'b0;
    det_cls_d  = det_cls_q;
    det_conf_d = det_conf_q;
    trig       = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      rcnt_d  = '0;
      peak_d  = '0;
    end else if (frame_valid) begin
      case (state_q)
        IDLE: begin
          if (qualify) begin
            cand_d  = frame_class;
            cnt_d   = 4'd1;
            peak_d  = frame_conf;
            state_d = TRACK;
            trig    = (cnt_d == HOLD_CNT);
          end
        end
        TRACK: begin
          if (qualify && (frame_class == cand_q)) begin
            cnt_d  = cnt_q + 4'd1;
            peak_d = prob_max(peak_q, frame_conf);
            trig   = (cnt_d == HOLD_CNT);
          end else if (qualify) begin
            cand_d = frame_class;
            cnt_d  = 4'd1;
            peak_d = frame_conf;
            trig   = (cnt_d == HOLD_CNT);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        REFRACT: begin
          // Frames here are discarded; leaving on the last one lets the next be evaluated
          if (rcnt_q != 8'd0) begin
            rcnt_d = rcnt_q - 8'd1;
          end
          if (rcnt_q <= 8'd1) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (trig) begin
        det_vld_d  = 1'b1;
        det_cls_d  = cand_d;
        det_conf_d = peak_d;
        cnt_d      = '0;
        peak_d     = '0;
        if (REFRACT_CNT == 8'd0) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          state_d = REFRACT;
          rcnt_d  = REFRACT_CNT;
        end
      end
    end
  end

  // State and detection registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      cand_q     <= '0;
      peak_q     <= '0;
      det_vld_q  <= 1'b0;
      det_cls_q  <= '0;
      det_conf_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      cand_q     <= cand_d;
      peak_q     <= peak_d;
      det_vld_q  <= det_vld_d;
      det_cls_q  <= det_cls_d;
      det_conf_q <= det_conf_d;
    end
  end

  assign bus.frame_valid  = frame_valid;
  assign bus.frame_class  = frame_class;
  assign bus.frame_conf   = frame_conf;
  assign bus.detect_valid = det_vld_q;
  assign bus.detect_class = det_cls_q;
  assign bus.detect_conf  = det_conf_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_kws_decision.sv
// Bench for kws_decision: directed scenarios plus randomized frames vs a frame-level model.
// Latency: model predicts frame outputs 1 cycle and detections 2 cycles after in_valid.
// Backpressure: none; flush is injected directly and randomly.
module tb_kws_decision;

  localparam int HOLD = 3;
  localparam int REFR = 8;
  localparam int THR  = 19661;
  localparam int SIL  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kws_decision_if bus();

  kws_decision dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus probabilities
  int pv [8];

  // Frame-level reference model state
  int m_run_len, m_run_cls, m_peak, m_refr;
  bit pend;
  int pend_cls, pend_conf;
  int e_fv, e_fc, e_fconf, e_dv, e_dc, e_dconf;
  int det_seen;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_probs();
    bus.prob_0 = 16'(pv[0]);
    bus.prob_1 = 16'(pv[1]);
    bus.prob_2 = 16'(pv[2]);
    bus.prob_3 = 16'(pv[3]);
    bus.prob_4 = 16'(pv[4]);
    bus.prob_5 = 16'(pv[5]);
    bus.prob_6 = 16'(pv[6]);
    bus.prob_7 = 16'(pv[7]);
  endtask

  task automatic set_frame(input int cls, input int conf);
    for (int i = 0; i < 8; i++) pv[i] = 1000;
    pv[cls] = conf;
  endtask

  task automatic model_clear();
    m_run_len = 0; m_run_cls = 0; m_peak = 0; m_refr = 0;
    pend = 0; pend_cls = 0; pend_conf = 0;
    e_fv = 0; e_fc = 0; e_fconf = 0; e_dv = 0; e_dc = 0; e_dconf = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".frame_valid"},  32'(bus.frame_valid),  e_fv);
    check({tag, ".frame_class"},  32'(bus.frame_class),  e_fc);
    check({tag, ".frame_conf"},   32'(bus.frame_conf),   e_fconf);
    check({tag, ".detect_valid"}, 32'(bus.detect_valid), e_dv);
    check({tag, ".detect_class"}, 32'(bus.detect_class), e_dc);
    check({tag, ".detect_conf"},  32'(bus.detect_conf),  e_dconf);
    check({tag, ".busy"},         32'(bus.busy),         (m_run_len > 0 || m_refr > 0) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance model, compare after the edge
  task automatic step(input bit iv, input bit fl);
    int best;
    rst = 1'b0;
    bus.in_valid = iv;
    bus.flush    = fl;
    drive_probs();

    e_dv = 0;
    if (fl) begin
      pend = 0; m_run_len = 0; m_refr = 0;
    end else if (pend) begin
      if (m_refr > 0) begin
        m_refr--;
      end else if (pend_conf >= THR && pend_cls != SIL) begin
        if (m_run_len > 0 && pend_cls == m_run_cls) begin
          m_run_len++;
          if (pend_conf > m_peak) m_peak = pend_conf;
        end else begin
          m_run_len = 1; m_run_cls = pend_cls; m_peak = pend_conf;
        end
        if (m_run_len == HOLD) begin
          e_dv = 1; e_dc = m_run_cls; e_dconf = m_peak;
          m_run_len = 0; m_refr = REFR;
        end
      end else begin
        m_run_len = 0;
      end
    end

    e_fv = (iv && !fl) ? 1 : 0;
    pend = iv && !fl;
    if (pend) begin
      best = 0;
      for (int i = 1; i < 8; i++) if (pv[i] > pv[best]) best = i;
      pend_cls = best; pend_conf = pv[best];
      e_fc = best; e_fconf = pv[best];
    end

    @(posedge clk);
    #1;
    if (bus.detect_valid === 1'b1) det_seen++;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.flush = 1'b0;
    set_frame(5, 30000);
    drive_probs();
    model_clear();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    det_seen = 0;
  endtask

  // Send n frames of one class, with occasional idle gaps between them
  task automatic run_frames(input int cls, input int conf, input int n);
    for (int k = 0; k < n; k++) begin
      set_frame(cls, conf);
      step(1, 0);
      if ($urandom_range(0, 2) == 0) step(0, 0);
    end
  endtask

  task automatic drain();
    repeat (3) step(0, 0);
  endtask

  initial begin
    int dom;
    bit iv, fl;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < 8; i++) pv[i] = 0;
    drive_probs();
    det_seen = 0;

    // Reset with in_valid high, then idle
    do_reset();
    repeat (5) step(0, 0);
    check("idle_no_detect", det_seen, 0);

    // Basic trigger with gaps; detect 2 cycles after the 3rd in_valid
    do_reset();
    set_frame(5, 20000); step(1, 0); step(0, 0);
    set_frame(5, 26000); step(1, 0); step(0, 0); step(0, 0);
    set_frame(5, 22000); step(1, 0);
    check("basic_not_early", 32'(bus.detect_valid), 0);
    step(0, 0);
    check("basic_dv", 32'(bus.detect_valid), 1);
    check("basic_dc", 32'(bus.detect_class), 5);
    check("basic_dconf", 32'(bus.detect_conf), 26000);
    drain();
    check("basic_count", det_seen, 1);

    // Threshold edge
    do_reset(); run_frames(2, 19660, 5); drain();
    check("thr_below_count", det_seen, 0);
    do_reset(); run_frames(2, 19661, 3); drain();
    check("thr_equal_count", det_seen, 1);
    do_reset(); run_frames(0, 30000, 5); drain();
    check("silence_count", det_seen, 0);

    // Candidate switch and dropped run
    do_reset(); run_frames(5, 25000, 2); run_frames(3, 25000, 3); drain();
    check("switch_count", det_seen, 1);
    check("switch_class", 32'(bus.detect_class), 3);
    do_reset(); run_frames(5, 25000, 2); run_frames(5, 100, 1); run_frames(5, 25000, 2); drain();
    check("drop_count", det_seen, 0);

    // Refractory window
    do_reset(); run_frames(4, 25000, 14); drain();
    check("refract_count", det_seen, 2);

    // Tie goes to the lowest index
    do_reset();
    for (int i = 0; i < 8; i++) pv[i] = 1000;
    pv[1] = 25000; pv[6] = 25000;
    step(1, 0);
    check("tie_class", 32'(bus.frame_class), 1);

    // Flush mid-run
    do_reset();
    run_frames(7, 25000, 2);
    step(0, 1);
    run_frames(7, 25000, 1);
    step(0, 0); step(0, 0);
    check("flush_count", det_seen, 0);
    check("flush_busy", 32'(bus.busy), 1);

    // Randomized frames, flushes, ties and negative probabilities
    do_reset();
    dom = 4;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) dom = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) begin
        pv[i] = $urandom_range(0, 12000);
        if ($urandom_range(0, 15) == 0) pv[i] = -int'($urandom_range(1, 32768));
      end
      pv[dom] = $urandom_range(15000, 32767);
      if ($urandom_range(0, 15) == 0) pv[(dom + 3) % 8] = pv[dom];
      iv = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 39) == 0);
      step(iv, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kws_decision.md
Name: kws_decision

Overview:
- Sits directly downstream of the 8-class softmax LUT stage.
- Each valid frame: picks the winning class and confidence, then applies temporal smoothing so a keyword is reported only after HOLD_FRAMES consecutive confident frames.
- After a report, a refractory window suppresses repeat triggers.
- Emits a single-cycle detection pulse with class index and peak confidence to the system controller.

Parameters:
- DATA_W, 16, probability width (signed, Q0.15; valid range 0..32767)
- THRESH, 16'sd19661, minimum winning probability for a qualifying frame (about 0.6)
- HOLD_FRAMES, 3, consecutive qualifying same-class frames needed to trigger (1..15)
- REFRACT_FRAMES, 8, valid frames ignored after a trigger (0..255)
- SILENCE_CLASS, 0, class index that never triggers

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  one frame of probabilities present this cycle
- prob_0 .. prob_7  in  16 each  signed softmax outputs
- flush  in  1  synchronous abort of tracking/refractory state
- frame_valid  out  1  registered per-frame argmax result valid
- frame_class  out  3  per-frame winning class
- frame_conf  out  16  per-frame winning probability
- detect_valid  out  1  single-cycle keyword detection pulse
- detect_class  out  3  detected class, held until next detection
- detect_conf  out  16  peak confidence over the triggering run, held until next detection
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0. rst dominates flush and in_valid.
- Stage A (sub-module), registered:
  - on in_valid at cycle t, frame_valid=1 at t+1 with argmax of signed compare; otherwise frame_valid=0.
  - Ties resolve to the lowest index. frame_class/frame_conf hold last value when frame_valid=0.
- Qualifying frame: frame_valid && frame_conf >= THRESH (signed) && frame_class != SILENCE_CLASS.
- Stage B FSM advances only on frame_valid. Gaps in in_valid do not break a run.
- IDLE:
  - Qualifying frame: cand=class, cnt=1, peak=conf, go TRACK.
  - If HOLD_FRAMES==1, trigger immediately instead.
- TRACK:
  - Qualifying frame with class==cand: cnt+1, peak=max(peak,conf). When cnt reaches HOLD_FRAMES, trigger.
  - Qualifying frame with a different class: restart with cand=new class, cnt=1, peak=conf.
  - Non-qualifying frame: go IDLE, cnt=0.
- Trigger (same cycle as the deciding frame's stage-B update): detect_valid=1 for exactly one cycle, and detect_class/detect_conf are loaded.
  - Latency: in_valid of the deciding frame at t, detect_valid at t+2.
  - Next state is REFRACT with rcnt=REFRACT_FRAMES, or IDLE if REFRACT_FRAMES==0.
- REFRACT:
  - Each frame_valid decrements rcnt and the frame is discarded, never evaluated.
  - When rcnt reaches 0, go IDLE; the next frame is evaluated.
- flush (when rst=0): FSM to IDLE, cnt/rcnt/peak cleared, stage A frame_valid cleared, so any in-flight frame is dropped. detect_class/detect_conf keep their values. A frame with in_valid in the same cycle as flush is dropped.
- busy = (state != IDLE).
- Counters saturate by construction; cnt is 4 bits and rcnt is 8 bits, with no wrap.

Decomposition:
- Package kws_pkg:
  - NUM_CLASSES=8, CLS_W=3, DATA_W=16
  - state enum {IDLE, TRACK, REFRACT}
  - Q0.15 threshold constants
- Sub-module kws_argmax8: registered 8-way signed argmax with lowest-index tie-break, producing frame_valid/frame_class/frame_conf.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with in_valid=1.
  - Required: all outputs 0 and busy=0 throughout; afterwards, no detect without frames.
- Basic trigger and latency:
  - Stimulus: 3 frames, gaps allowed; prob_5 = 20000, 26000, 22000; all other probs 1000.
  - Required: exactly one detect_valid, 2 cycles after the 3rd in_valid, with detect_class=5 and detect_conf=26000.
- Threshold edge:
  - Stimulus A: class 2 at 19660 for 5 frames. Required: no detect.
  - Stimulus B: repeat at 19661. Required: detect on the 3rd frame.
  - Stimulus C: class 0 at 30000 for 5 frames. Required: no detect.
- Candidate switch and drop:
  - Stimulus A: frames class 5,5,3,3,3. Required: one detect, class 3, after the 5th frame.
  - Stimulus B: frames 5,5,(conf 100),5,5. Required: no detect.
- Refractory:
  - Stimulus: 14 frames class 4 at 25000.
  - Required: detects after frames 3 and 14 only; busy=1 from frame 1 through frame 14 plus latency.
- Tie and flush:
  - Stimulus A: prob_1 = prob_6 = 25000. Required: frame_class=1.
  - Stimulus B: 2 frames class 7, flush, 1 frame class 7. Required: no detect, busy=1 after the last frame.
